// File: rtl/studio2_pkg.sv
// Shared types and memory-map constants for the Studio II memory arbiter.
package studio2_pkg;

    typedef enum logic [1:0] {
        REG_ROM,
        REG_RAM,
        REG_MCART,
        REG_OOR
    } region_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_DMA,
        GNT_LD
    } grant_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE
    } state_t;

    // Region boundaries of the console memory map (each is the first address of a region)
    localparam logic [15:0] RAM_BASE    = 16'h0800;
    localparam logic [15:0] MCART0_BASE = 16'h0A00;
    localparam logic [15:0] MIRROR_BASE = 16'h0C00;
    localparam logic [15:0] MCART1_BASE = 16'h0E00;
    localparam logic [15:0] OOR_BASE    = 16'h1000;

    // The 0C00-0DFF window is the 0800-09FF RAM with address bit 10 set
    function automatic logic [11:0] fold_mirror(input logic [11:0] a);
        return a & ~12'h400;
    endfunction

endpackage

// File: rtl/studio2_addr_decode.sv
// Combinational memory-map decode: classifies a CPU/DMA address, folds the
// RAM mirror onto its physical location and decides whether the access may proceed.
module studio2_addr_decode
    import studio2_pkg::*;
#(
    parameter bit MCART_WR = 1'b0
) (
    input  logic [15:0] addr,
    input  logic        wr,
    output region_t     region,
    output logic [11:0] phys_addr,
    output logic        allowed
);

    // Range compare chain, lowest region first
    always_comb begin
        region    = REG_OOR;
        phys_addr = addr[11:0];
        allowed   = 1'b0;
        if (addr >= OOR_BASE) begin
            region  = REG_OOR;
            allowed = 1'b0;
        end else if (addr < RAM_BASE) begin
            region  = REG_ROM;
            allowed = !wr;
        end else if (addr < MCART0_BASE) begin
            region  = REG_RAM;
            allowed = 1'b1;
        end else if (addr < MIRROR_BASE) begin
            region  = REG_MCART;
            allowed = !wr || MCART_WR;
        end else if (addr < MCART1_BASE) begin
            region    = REG_RAM;
            phys_addr = fold_mirror(addr[11:0]);
            allowed   = 1'b1;
        end else begin
            region  = REG_MCART;
            allowed = !wr || MCART_WR;
        end
    end

endmodule

// File: rtl/studio2_mem_arbiter.sv
// Three-way arbiter (loader, video DMA, CPU) in front of the single 4 KiB
// Studio II memory. One access at a time: IDLE (arbitrate) -> ISSUE (memory
// strobe) -> DONE (ack + read data).
module studio2_mem_arbiter
    import studio2_pkg::*;
#(
    parameter bit         MCART_WR = 1'b0,
    parameter logic [7:0] OOR_DATA = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,

    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,

    input  logic        ld_active,
    input  logic        ld_wr,
    input  logic [11:0] ld_addr,
    input  logic [7:0]  ld_data,

    output logic        mem_ce,
    output logic        mem_wr,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_q,

    output logic        bad_access
);

    state_t      state;
    grant_t      grant;
    grant_t      pick;
    logic        rr_cpu;

    logic        ld_pend;
    logic        ld_capture;
    logic [11:0] ld_pend_addr;
    logic [7:0]  ld_pend_data;

    logic [15:0] dec_addr;
    logic        dec_wr;
    region_t     dec_region;
    logic [11:0] dec_phys;
    logic        dec_allowed;

    logic [11:0] nxt_phys;
    logic [7:0]  nxt_wdata;
    logic        nxt_wr;
    logic        nxt_legal;
    logic        nxt_oor;

    logic        acc_legal;
    logic        acc_oor;
    logic [7:0]  rd_now;
    logic [7:0]  cpu_rdata_q;
    logic [7:0]  dma_rdata_q;

    // Winner selection: loader first, then CPU/DMA by round-robin unless a download is running
    always_comb begin
        pick = GNT_NONE;
        if (ld_pend || ld_wr) begin
            pick = GNT_LD;
        end else if (!ld_active) begin
            if (cpu_req && dma_req) begin
                pick = rr_cpu ? GNT_CPU : GNT_DMA;
            end else if (cpu_req) begin
                pick = GNT_CPU;
            end else if (dma_req) begin
                pick = GNT_DMA;
            end
        end
    end

    assign dec_addr = (pick == GNT_CPU) ? cpu_addr : dma_addr;
    assign dec_wr   = (pick == GNT_CPU) && cpu_wr;

    studio2_addr_decode #(
        .MCART_WR (MCART_WR)
    ) u_decode (
        .addr      (dec_addr),
        .wr        (dec_wr),
        .region    (dec_region),
        .phys_addr (dec_phys),
        .allowed   (dec_allowed)
    );

    // Next access descriptor; loader writes skip the decoder and always land
    always_comb begin
        nxt_phys  = dec_phys;
        nxt_wdata = cpu_wdata;
        nxt_wr    = dec_wr;
        nxt_legal = dec_allowed;
        nxt_oor   = (dec_region == REG_OOR);
        if (pick == GNT_LD) begin
            nxt_phys  = ld_pend ? ld_pend_addr : ld_addr;
            nxt_wdata = ld_pend ? ld_pend_data : ld_data;
            nxt_wr    = 1'b1;
            nxt_legal = 1'b1;
            nxt_oor   = 1'b0;
        end
    end

    // A loader strobe that cannot be taken this cycle is parked for the next IDLE
    assign ld_capture = ld_wr && ((state != ST_IDLE) || ld_pend);

    // The memory returns data in the DONE cycle, so the ack cycle forwards it directly
    assign rd_now    = acc_oor ? OOR_DATA : mem_q;
    assign cpu_rdata = cpu_ack ? rd_now : cpu_rdata_q;
    assign dma_rdata = dma_ack ? rd_now : dma_rdata_q;

    // Access sequencer, grant/round-robin bookkeeping and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant       <= GNT_NONE;
            rr_cpu      <= 1'b1;
            ld_pend     <= 1'b0;
            mem_ce      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            bad_access  <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (ld_capture) begin
                ld_pend <= 1'b1;
            end else if ((state == ST_IDLE) && ld_pend) begin
                ld_pend <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (pick != GNT_NONE) begin
                        state    <= ST_ISSUE;
                        grant    <= pick;
                        mem_ce   <= nxt_legal;
                        mem_wr   <= nxt_wr && nxt_legal;
                        mem_addr <= nxt_phys;
                        mem_din  <= nxt_wdata;
                        if (pick == GNT_CPU) begin
                            rr_cpu <= 1'b0;
                        end else if (pick == GNT_DMA) begin
                            rr_cpu <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state      <= ST_DONE;
                    mem_ce     <= 1'b0;
                    mem_wr     <= 1'b0;
                    cpu_ack    <= (grant == GNT_CPU);
                    dma_ack    <= (grant == GNT_DMA);
                    bad_access <= !acc_legal;
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    grant      <= GNT_NONE;
                    cpu_ack    <= 1'b0;
                    dma_ack    <= 1'b0;
                    bad_access <= 1'b0;
                    if (cpu_ack) begin
                        cpu_rdata_q <= rd_now;
                    end
                    if (dma_ack) begin
                        dma_rdata_q <= rd_now;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= GNT_NONE;
                end
            endcase
        end
    end

    // Per-access attributes and the parked loader write (data only, no reset needed)
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && (pick != GNT_NONE)) begin
            acc_legal <= nxt_legal;
            acc_oor   <= nxt_oor;
        end
        if (ld_capture) begin
            ld_pend_addr <= ld_addr;
            ld_pend_data <= ld_data;
        end
    end

endmodule

// File: tb/tb_studio2_mem_arbiter.sv
// Scoreboard bench for studio2_mem_arbiter with a behavioural synchronous RAM.
module tb_studio2_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic        ld_active, ld_wr;
    logic [11:0] ld_addr;
    logic [7:0]  ld_data;
    logic        mem_ce, mem_wr;
    logic [11:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_q;
    logic        bad_access;

    always #5 clk = ~clk;

    studio2_mem_arbiter #(
        .MCART_WR (1'b0),
        .OOR_DATA (8'hFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_ack    (dma_ack),
        .dma_rdata  (dma_rdata),
        .ld_active  (ld_active),
        .ld_wr      (ld_wr),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .mem_ce     (mem_ce),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_q      (mem_q),
        .bad_access (bad_access)
    );

    typedef struct {
        logic [7:0] rdata;
        logic       chk_rd;
        logic       bad;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [7:0]  din;
    } memx_t;

    rsp_t  cpu_exp_q[$];
    rsp_t  dma_exp_q[$];
    memx_t mem_exp_q[$];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [7:0] ram [4096];
    logic [7:0] shadow [4096];
    logic       mem_init;

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] v;
        v = i[7:0] ^ 8'h3C;
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: one-cycle read latency
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
        end else if (mem_ce) begin
            if (mem_wr) ram[mem_addr] <= mem_din;
            else        mem_q <= ram[mem_addr];
        end
    end

    // Output monitor: pops expectations as the DUT produces memory strobes and acks
    always @(negedge clk) begin
        memx_t m;
        rsp_t  r;
        if (mem_ce === 1'b1) begin
            check_eq("mem_expected", mem_exp_q.size() > 0, 1);
            if (mem_exp_q.size() > 0) begin
                m = mem_exp_q.pop_front();
                check_eq("mem_wr", mem_wr, m.wr);
                check_eq("mem_addr", mem_addr, m.addr);
                if (m.wr) check_eq("mem_din", mem_din, m.din);
            end
        end
        if (cpu_ack === 1'b1) begin
            check_eq("cpu_ack_expected", cpu_exp_q.size() > 0, 1);
            if (cpu_exp_q.size() > 0) begin
                r = cpu_exp_q.pop_front();
                if (r.chk_rd) check_eq("cpu_rdata", cpu_rdata, r.rdata);
                check_eq("cpu_bad_access", bad_access, r.bad);
            end
        end
        if (dma_ack === 1'b1) begin
            check_eq("dma_ack_expected", dma_exp_q.size() > 0, 1);
            if (dma_exp_q.size() > 0) begin
                r = dma_exp_q.pop_front();
                check_eq("dma_rdata", dma_rdata, r.rdata);
                check_eq("dma_bad_access", bad_access, r.bad);
            end
        end
        if (bad_access === 1'b1 && cpu_ack !== 1'b1 && dma_ack !== 1'b1)
            check_eq("bad_without_ack", bad_access, 0);
    end

    // Independent memory-map model: pushes response/memory expectations and updates the shadow
    task automatic expect_access(input logic is_dma, input logic [15:0] a, input logic w, input logic [7:0] d);
        logic        oor, legal;
        logic [11:0] phys;
        rsp_t        r;
        memx_t       m;
        oor  = (a >= 16'h1000);
        phys = a[11:0];
        if (oor)                 legal = 1'b0;
        else if (a < 16'h0800)   legal = !w;
        else if (a < 16'h0A00)   legal = 1'b1;
        else if (a < 16'h0C00)   legal = !w;
        else if (a < 16'h0E00) begin
            legal = 1'b1;
            phys  = a[11:0] - 12'h400;
        end else                 legal = !w;
        r.rdata  = oor ? 8'hFF : shadow[phys];
        r.chk_rd = !w;
        r.bad    = !legal;
        if (is_dma) dma_exp_q.push_back(r);
        else        cpu_exp_q.push_back(r);
        if (legal) begin
            m.wr = w; m.addr = phys; m.din = d;
            mem_exp_q.push_back(m);
            if (w) shadow[phys] = d;
        end
    endtask

    // Single request/ack handshake with latency check (exp_lat < 0 skips it)
    task automatic req_op(input string tag, input logic is_dma, input logic [15:0] a,
                          input logic w, input logic [7:0] d, input int exp_lat);
        int   t0;
        logic got;
        expect_access(is_dma, a, w, d);
        if (is_dma) begin
            dma_addr = a; dma_req = 1'b1;
        end else begin
            cpu_addr = a; cpu_wr = w; cpu_wdata = d; cpu_req = 1'b1;
        end
        t0  = cyc;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (is_dma ? dma_ack : cpu_ack) got = 1'b1;
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        check_eq({tag, "_ack"}, got, 1);
        if (got && exp_lat >= 0) check_eq({tag, "_lat"}, cyc - t0, exp_lat);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int who [8];
        int when [8];
        int n, nc, nd;
        logic got;

        reset = 1'b1; mem_init = 1'b1;
        cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_addr = 0;
        ld_active = 0; ld_wr = 0; ld_addr = 0; ld_data = 0;
        for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);
        repeat (3) @(negedge clk);
        mem_init = 1'b0;

        check_eq("rst_acks_ce", {cpu_ack, dma_ack, mem_ce, mem_wr, bad_access}, 5'b0);
        check_eq("rst_mem_bus", {mem_addr, mem_din}, 20'h0);
        check_eq("rst_rdata", {cpu_rdata, dma_rdata}, 16'h0);
        reset = 1'b0;
        @(negedge clk);

        req_op("wr_mirror", 0, 16'h0C10, 1, 8'h5A, 2);
        req_op("rd_ram",    0, 16'h0810, 0, 8'h00, 2);
        req_op("wr_rom",    0, 16'h0123, 1, 8'hAA, 2);
        check_eq("rom_unchanged", ram[12'h123], init_val(32'h123));
        req_op("rd_rom",    0, 16'h0123, 0, 8'h00, 2);
        req_op("rd_oor",    0, 16'h2000, 0, 8'h00, 2);
        req_op("wr_oor",    0, 16'h1000, 1, 8'h11, -1);
        req_op("wr_mcart",  0, 16'h0A05, 1, 8'h77, -1);
        check_eq("mcart_unchanged", ram[12'hA05], init_val(32'hA05));
        req_op("dma_rd",    1, 16'h0810, 0, 8'h00, 2);
        req_op("rd_mcart",  0, 16'h0E05, 0, 8'h00, 2);

        // Contention: both requesters held; pointer now favours DMA
        for (int k = 0; k < 4; k++) begin
            expect_access(1, 16'h0E05, 0, 8'h00);
            expect_access(0, 16'h0810, 0, 8'h00);
        end
        dma_addr = 16'h0E05; cpu_addr = 16'h0810; cpu_wr = 0;
        dma_req = 1; cpu_req = 1;
        n = 0; nc = 0; nd = 0;
        for (int i = 0; i < 60 && (nc < 4 || nd < 4); i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                if (n < 8) begin who[n] = 1; when[n] = cyc; end
                n++; nc++;
                if (nc == 4) cpu_req = 0;
            end
            if (dma_ack) begin
                if (n < 8) begin who[n] = 2; when[n] = cyc; end
                n++; nd++;
                if (nd == 4) dma_req = 0;
            end
        end
        cpu_req = 0; dma_req = 0;
        check_eq("rr_ack_count", n, 8);
        for (int i = 0; i < 8 && i < n; i++) check_eq("rr_order", who[i], (i % 2 == 0) ? 2 : 1);
        for (int i = 1; i < 8 && i < n; i++) check_eq("rr_spacing", when[i] - when[i-1], 3);
        @(negedge clk);

        // Loader holds off the CPU while a download is active
        ld_active = 1; cpu_addr = 16'h0400; cpu_wr = 0; cpu_req = 1;
        for (int i = 0; i < 16; i++) begin
            memx_t m;
            m.wr = 1; m.addr = 12'h400 + 12'(i); m.din = 8'hC0 + 8'(i);
            mem_exp_q.push_back(m);
            shadow[m.addr] = m.din;
            ld_addr = m.addr; ld_data = m.din; ld_wr = 1;
            @(negedge clk);
            check_eq("ld_blocks_cpu", cpu_ack, 0);
            ld_wr = 0;
            repeat (2) begin
                @(negedge clk);
                check_eq("ld_blocks_cpu", cpu_ack, 0);
            end
        end
        check_eq("ld_writes_done", mem_exp_q.size(), 0);
        check_eq("ld_last_byte", ram[12'h40F], 8'hCF);
        expect_access(0, 16'h0400, 0, 8'h00);
        ld_active = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (cpu_ack) got = 1;
        end
        cpu_req = 0;
        check_eq("cpu_after_ld", got, 1);
        @(negedge clk);

        // Reset during ISSUE aborts the CPU read
        begin
            memx_t m;
            m.wr = 0; m.addr = 12'h810; m.din = 0;
            mem_exp_q.push_back(m);
        end
        cpu_addr = 16'h0810; cpu_wr = 0; cpu_req = 1;
        @(negedge clk);
        check_eq("abort_in_issue", mem_ce, 1);
        reset = 1; cpu_req = 0;
        @(negedge clk);
        check_eq("abort_ctrl_zero", {cpu_ack, dma_ack, mem_ce, mem_wr, bad_access}, 5'b0);
        check_eq("abort_bus_zero", {mem_addr, mem_din}, 20'h0);
        check_eq("abort_rdata_zero", {cpu_rdata, dma_rdata}, 16'h0);
        reset = 0;
        repeat (4) begin
            @(negedge clk);
            check_eq("abort_no_ack", cpu_ack, 0);
        end
        req_op("rd_after_rst", 0, 16'h0810, 0, 8'h00, 2);

        check_eq("cpu_q_empty", cpu_exp_q.size(), 0);
        check_eq("dma_q_empty", dma_exp_q.size(), 0);
        check_eq("mem_q_empty", mem_exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/studio2_mem_arbiter.md
# studio2_mem_arbiter

Shares the single 4 KiB system RAM/cartridge array of the RCA Studio II core between three requesters: the CDP1802 CPU bus, the CDP1861/pixie video DMA fetch, and the ioctl cartridge loader. It decodes the console memory map, folds mirrored regions onto physical addresses and blocks illegal writes. It issues one sequenced access at a time to the synchronous memory and returns read data and an acknowledge to the granted requester. It sits between `cdp1802`/`pixie_dp`/ioctl and `dpram` port A.

## Interface
Parameters:
- `MCART_WR`, 0: when 1, writes to 0A00–0BFF and 0E00–0FFF are allowed (multicart RAM); when 0 they are dropped.
- `OOR_DATA`, 8'hFF: read data returned for addresses ≥ 16'h1000.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  system clock.
  - `reset`  in  1  synchronous, active-high.
- CPU requester:
  - `cpu_req`  in  1  CPU access request; held until `cpu_ack`.
  - `cpu_wr`  in  1  1 = write.
  - `cpu_addr`  in  16  CPU byte address.
  - `cpu_wdata`  in  8  CPU write data.
  - `cpu_ack`  out  1  one-cycle completion pulse.
  - `cpu_rdata`  out  8  CPU read data, valid while `cpu_ack`=1.
- Video DMA requester (read-only):
  - `dma_req`  in  1  video DMA read request.
  - `dma_addr`  in  16  video DMA address.
  - `dma_ack`  out  1  one-cycle completion pulse.
  - `dma_rdata`  out  8  DMA read data, valid while `dma_ack`=1.
- Loader:
  - `ld_active`  in  1  ioctl download in progress.
  - `ld_wr`  in  1  one-cycle loader write strobe.
  - `ld_addr`  in  12  physical loader address.
  - `ld_data`  in  8  loader write data.
- Memory port:
  - `mem_ce`  out  1  memory access enable.
  - `mem_wr`  out  1  memory write enable.
  - `mem_addr`  out  12  physical memory address.
  - `mem_din`  out  8  memory write data.
  - `mem_q`  in  8  memory read data, valid 1 cycle after `mem_ce`.
- Status:
  - `bad_access`  out  1  one-cycle pulse when a write is dropped or an out-of-range access occurs.

## Operation
- States: IDLE, ISSUE, DONE. Grant register: NONE, CPU, DMA, LD.
- IDLE: arbitrate and latch the winner's address, data and rw, then go to ISSUE. No requester: stay in IDLE.
- Priority:
  - LD (`ld_wr`) is absolute.
  - Between DMA and CPU, round-robin: after a DMA grant, a pending CPU wins next; otherwise DMA wins.
- While `ld_active`=1, CPU and DMA are never granted. Their requests stay pending with no ack.
- Decode (`studio2_addr_decode`):
  - 0000–07FF ROM/cart: read allowed, write dropped.
  - 0800–09FF RAM: read/write.
  - 0C00–0DFF mirrors onto 0800–09FF (addr[10]=0).
  - 0A00–0BFF and 0E00–0FFF multicart: write allowed only if `MCART_WR`.
  - ≥ 1000: out of range.
  - LD accesses bypass decode and are always written.
- ISSUE:
  - Legal access: `mem_ce`=1, `mem_wr`=rw, `mem_addr`=physical address, `mem_din`=data.
  - Dropped or out-of-range access: `mem_ce`=0.
  - Always go to DONE.
- DONE:
  - Pulse the granted requester's ack.
  - Read data = `mem_q`, or `OOR_DATA` if out of range. A dropped write completes normally with an ack.
  - Pulse `bad_access` if the access was dropped or out of range.
  - Go to IDLE. LD gets no ack.
- A requester deasserts req the cycle after its ack. A req still high in the cycle after ack is treated as a new request.

## Timing
- Reset values: all outputs 0, state IDLE, round-robin pointer favours CPU.
- Reset asserted in ISSUE or DONE aborts the access: no ack is issued and `mem_ce` drops the next cycle.
- Request sampled in IDLE at cycle N:
  - N+1: `mem_ce` asserted.
  - N+2: ack and rdata.
- Access period is 3 cycles. Worst-case CPU wait with DMA contending is 6 cycles (LD excluded).
- `cpu_rdata`/`dma_rdata` are registered and hold their value until the next ack to that requester.
- Simultaneous LD+DMA+CPU in IDLE: LD first. DMA/CPU order then follows the round-robin pointer, which updates only on DMA/CPU grants.

## Structure
- `studio2_pkg`:
  - region enum (ROM, RAM, MCART, OOR);
  - grant enum;
  - state enum;
  - region base/limit constants (16'h0800, 16'h0A00, 16'h0C00, 16'h0E00, 16'h1000).
- Sub-module `studio2_addr_decode`: combinational; inputs addr[15:0] and wr; outputs region, phys_addr[11:0] and allowed.

## Test plan
- CPU write 8'h5A to 16'h0C10, then read 16'h0810 -> `mem_addr`=12'h810 on the write; the read acks with 8'h5A 2 cycles after sampling.
- CPU write to 16'h0123 -> `mem_ce` stays 0, `cpu_ack` and `bad_access` pulse together, memory unchanged.
- CPU read 16'h2000 -> `cpu_rdata`=8'hFF, `bad_access`=1, no `mem_ce`.
- `cpu_req` and `dma_req` both held continuously -> grants alternate DMA, CPU, DMA, CPU with acks every 3 cycles.
- `ld_active`=1 with `ld_wr` writing 12'h400..12'h40F while `cpu_req` is high -> 16 memory writes, no `cpu_ack` until `ld_active`=0, then the CPU is served.
- `reset` asserted in ISSUE of a CPU read -> no `cpu_ack`, all outputs 0 the next cycle, state IDLE.
